// File: rtl/alu_pkg.sv
// Shared encodings and default widths for the hierarchical ALU command path.
package alu_pkg;

    localparam int unsigned IN_WIDTH_DEF  = 8;
    localparam int unsigned OUT_WIDTH_DEF = 16;

    // Unit select carried in CMD_FUN[3:2]
    localparam logic [1:0] UNIT_ARITH = 2'b00;
    localparam logic [1:0] UNIT_LOGIC = 2'b01;
    localparam logic [1:0] UNIT_CMP   = 2'b10;
    localparam logic [1:0] UNIT_SHIFT = 2'b11;

    // Sequencer state encoding
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] EXEC = 2'b01;
    localparam logic [1:0] CAPT = 2'b10;
    localparam logic [1:0] DONE = 2'b11;

    // One-hot enable vector, bit order {SHIFT, CMP, LOGIC, ARITH}
    function automatic logic [3:0] unit_onehot(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/alu_unit_decoder.sv
// Combinational unit decode: command select to one-hot enables, and
// result/flag mux driven by the latched select.
module alu_unit_decoder
    import alu_pkg::*;
#(
    parameter int unsigned out_width = OUT_WIDTH_DEF
)
(
    input  logic [1:0]           i_cmd_sel,
    output logic [3:0]           o_enable,
    input  logic [1:0]           i_res_sel,
    input  logic [out_width-1:0] i_arith_out,
    input  logic [out_width-1:0] i_logic_out,
    input  logic [out_width-1:0] i_cmp_out,
    input  logic [out_width-1:0] i_shift_out,
    input  logic                 i_arith_flag,
    input  logic                 i_logic_flag,
    input  logic                 i_cmp_flag,
    input  logic                 i_shift_flag,
    output logic [out_width-1:0] o_res,
    output logic                 o_flag
);

    assign o_enable = unit_onehot(i_cmd_sel);

    // Select the result and flag of the unit that executed the op
    always_comb begin
        o_res  = '0;
        o_flag = 1'b0;
        case (i_res_sel)
            UNIT_ARITH: begin o_res = i_arith_out; o_flag = i_arith_flag; end
            UNIT_LOGIC: begin o_res = i_logic_out; o_flag = i_logic_flag; end
            UNIT_CMP:   begin o_res = i_cmp_out;   o_flag = i_cmp_flag;   end
            default:    begin o_res = i_shift_out; o_flag = i_shift_flag; end
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command stage for the hierarchical ALU: accepts one op, enables one unit
// for a cycle, captures its registered result and holds it until taken.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned in_width  = IN_WIDTH_DEF,
    parameter int unsigned out_width = OUT_WIDTH_DEF
)
(
    input  logic                 clk,
    input  logic                 RST,
    input  logic                 CMD_Valid,
    output logic                 CMD_Ready,
    input  logic [3:0]           CMD_FUN,
    input  logic [in_width-1:0]  CMD_A,
    input  logic [in_width-1:0]  CMD_B,
    output logic [in_width-1:0]  A,
    output logic [in_width-1:0]  B,
    output logic [1:0]           ALU_FUN,
    output logic                 ARITH_Enable,
    output logic                 LOGIC_Enable,
    output logic                 CMP_Enable,
    output logic                 SHIFT_Enable,
    input  logic [out_width-1:0] ARITH_OUT,
    input  logic [out_width-1:0] LOGIC_OUT,
    input  logic [out_width-1:0] CMP_OUT,
    input  logic [out_width-1:0] SHIFT_OUT,
    input  logic                 ARITH_Flag,
    input  logic                 LOGIC_Flag,
    input  logic                 CMP_Flag,
    input  logic                 SHIFT_Flag,
    output logic [out_width-1:0] RES_OUT,
    output logic                 RES_Flag,
    output logic                 RES_Valid,
    input  logic                 RES_Ready
);

    logic [1:0]           r_state;
    logic [in_width-1:0]  r_a;
    logic [in_width-1:0]  r_b;
    logic [1:0]           r_fun;
    logic [1:0]           r_sel;
    logic [3:0]           r_en;
    logic [out_width-1:0] r_res;
    logic                 r_flag;
    logic                 r_res_valid;

    logic [3:0]           w_dec_en;
    logic [out_width-1:0] w_mux_res;
    logic                 w_mux_flag;
    logic                 w_accept;
    logic                 w_release;

    assign w_accept  = CMD_Valid && (r_state == IDLE);
    assign w_release = RES_Ready && (r_state == DONE);

    alu_unit_decoder #(.out_width(out_width)) u_dec (
        .i_cmd_sel    (CMD_FUN[3:2]),
        .o_enable     (w_dec_en),
        .i_res_sel    (r_sel),
        .i_arith_out  (ARITH_OUT),
        .i_logic_out  (LOGIC_OUT),
        .i_cmp_out    (CMP_OUT),
        .i_shift_out  (SHIFT_OUT),
        .i_arith_flag (ARITH_Flag),
        .i_logic_flag (LOGIC_Flag),
        .i_cmp_flag   (CMP_Flag),
        .i_shift_flag (SHIFT_Flag),
        .o_res        (w_mux_res),
        .o_flag       (w_mux_flag)
    );

    // State sequencing: IDLE -> EXEC -> CAPT -> DONE -> IDLE
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_accept) r_state <= EXEC;
                EXEC:    r_state <= CAPT;
                CAPT:    r_state <= DONE;
                default: if (w_release) r_state <= IDLE;
            endcase
        end
    end

    // Operand/function latch held until the next accept; enable lives for EXEC only
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_a   <= '0;
            r_b   <= '0;
            r_fun <= '0;
            r_sel <= '0;
            r_en  <= '0;
        end else if (w_accept) begin
            r_a   <= CMD_A;
            r_b   <= CMD_B;
            r_fun <= CMD_FUN[1:0];
            r_sel <= CMD_FUN[3:2];
            r_en  <= w_dec_en;
        end else begin
            r_en  <= '0;
        end
    end

    // Result register: loaded leaving CAPT, valid held until the consumer takes it
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_res       <= '0;
            r_flag      <= 1'b0;
            r_res_valid <= 1'b0;
        end else if (r_state == CAPT) begin
            r_res       <= w_mux_res;
            r_flag      <= w_mux_flag;
            r_res_valid <= 1'b1;
        end else if (w_release) begin
            r_res_valid <= 1'b0;
        end
    end

    assign CMD_Ready    = (r_state == IDLE);
    assign A            = r_a;
    assign B            = r_b;
    assign ALU_FUN      = r_fun;
    assign ARITH_Enable = r_en[0];
    assign LOGIC_Enable = r_en[1];
    assign CMP_Enable   = r_en[2];
    assign SHIFT_Enable = r_en[3];
    assign RES_OUT      = r_res;
    assign RES_Flag     = r_flag;
    assign RES_Valid    = r_res_valid;

endmodule
